// File: rtl/lfsr_noise_player.sv
// lfsr_noise_player
// Streams words out of a combinational noise lookup ROM. The address is
// stepped by a programmable stride at a programmable rate, each word is
// scaled by an unsigned Q1.7 gain with saturation, and the result is offered
// on a valid/ready stream. A sample that arrives while the previous one is
// still unconsumed is dropped and flagged with a one-clock overrun pulse.

module lfsr_noise_player #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_step,
  input  logic [DIV_W-1:0]  i_rate_div,
  input  logic [7:0]        i_gain,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_lut_data,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun
);

  // Two-state controller; kept as plain constants for legacy tool flows.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Product of a signed DATA_W word and a zero-extended 8-bit gain.
  localparam int PROD_W = DATA_W + 9;

  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  DIV_ZERO = '0;
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  // State registers
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;
  logic              r_overrun;

  // Next-state values
  logic [0:0]        w_state_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [DIV_W-1:0]  w_div_nx;
  logic [DATA_W-1:0] w_sample_nx;
  logic              w_valid_nx;
  logic              w_overrun_nx;

  // Datapath and control terms
  logic signed [PROD_W-1:0] w_product;
  logic signed [PROD_W-1:0] w_shifted;
  logic                     w_fits;
  logic [DATA_W-1:0]        w_sat;
  logic                     w_strobe;
  logic                     w_handshake;
  logic                     w_blocked;

  // Gain multiply, arithmetic shift back to Q0, then clamp to DATA_W.
  always_comb begin
    w_product = $signed(i_lut_data) * $signed({1'b0, i_gain});
    w_shifted = w_product >>> 7;
    // The shifted value fits when every bit from the DATA_W sign bit upward
    // agrees; otherwise clamp toward the sign of the full-width result.
    w_fits = (&w_shifted[PROD_W-1:DATA_W-1]) | ~(|w_shifted[PROD_W-1:DATA_W-1]);
    if (w_fits) begin
      w_sat = w_shifted[DATA_W-1:0];
    end else if (w_shifted[PROD_W-1]) begin
      w_sat = SAT_MIN;
    end else begin
      w_sat = SAT_MAX;
    end
  end

  // Strobe uses >= so a live reduction of the rate below the running count
  // fires at once instead of waiting for the counter to wrap.
  assign w_strobe    = (r_div >= i_rate_div);
  assign w_handshake = r_valid & i_ready;
  assign w_blocked   = r_valid & ~i_ready;

  // Controller: next-state and output-register values for the coming edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nx   = r_state;
    w_addr_nx    = r_addr;
    w_div_nx     = r_div;
    w_sample_nx  = r_sample;
    w_valid_nx   = r_valid;
    w_overrun_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_valid_nx = 1'b0;
        if (i_en) begin
          w_state_nx = S_RUN;
          w_addr_nx  = i_start_addr;
          w_div_nx   = DIV_ZERO;
        end
      end

      S_RUN: begin
        if (!i_en) begin
          // Leaving the stream: any pending sample is withdrawn.
          w_state_nx = S_IDLE;
          w_div_nx   = DIV_ZERO;
          w_valid_nx = 1'b0;
        end else if (w_strobe) begin
          w_div_nx  = DIV_ZERO;
          // The address advances even on a drop so table timing stays fixed.
          w_addr_nx = r_addr + i_step;
          if (w_blocked) begin
            w_overrun_nx = 1'b1;
          end else begin
            w_sample_nx = w_sat;
            w_valid_nx  = 1'b1;
          end
        end else begin
          w_div_nx = r_div + DIV_ONE;
          if (w_handshake) begin
            w_valid_nx = 1'b0;
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // State update with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_div     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state   <= w_state_nx;
      r_addr    <= w_addr_nx;
      r_div     <= w_div_nx;
      r_sample  <= w_sample_nx;
      r_valid   <= w_valid_nx;
      r_overrun <= w_overrun_nx;
    end
  end

  assign o_addr    = r_addr;
  assign o_sample  = r_sample;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule
